// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder control slice: state encoding,
// parameter defaults and a small width helper.
package turbo_pkg;

  localparam int DEF_LEN_W       = 17;
  localparam int DEF_MAX_LEN     = 6144;
  localparam int DEF_CLR_CYCLES  = 1;
  localparam int DEF_TAIL_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ENCODE = 3'd2,
    ST_TAIL   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/turbo_phase_cnt.sv
// Loadable down-counter that times each FSM phase; the next value is exported
// so the controller can register its outputs in step with the count.
module turbo_phase_cnt
  import turbo_pkg::*;
#(
  parameter int CNT_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero so a stray decrement can never wrap the phase length
  always_comb begin
    o_cnt_nxt = r_cnt;
    if (i_load) begin
      o_cnt_nxt = i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      o_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_nxt;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/turbo_ctrl_fsm.sv
// Turbo encoder block controller: sequences clear, encode and tail phases for
// one block per request, with abort and illegal-length error handling.
module turbo_ctrl_fsm
  import turbo_pkg::*;
#(
  parameter int LEN_W       = DEF_LEN_W,
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int CLR_CYCLES  = DEF_CLR_CYCLES,
  parameter int TAIL_CYCLES = DEF_TAIL_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [LEN_W-1:0] length,
  input  logic             term_en,
  input  logic             abort,
  output logic             ready,
  output logic             clr,
  output logic             enable,
  output logic             tail_en,
  output logic [LEN_W-1:0] bit_idx,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = max3(LEN_W, $clog2(CLR_CYCLES + 1), $clog2(TAIL_CYCLES + 1));
  localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TAIL_LOAD = CNT_W'((TAIL_CYCLES > 0) ? TAIL_CYCLES - 1 : 0);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic             r_term;
  logic             w_term_nxt;
  logic             w_err_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_zero;
  logic             w_len_bad;
  logic [CNT_W-1:0] w_enc_last;

  logic             r_ready;
  logic             r_clr;
  logic             r_enable;
  logic             r_tail_en;
  logic [LEN_W-1:0] r_bit_idx;
  logic             r_done;
  logic             r_err;

  turbo_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_cnt_nxt  (w_cnt_nxt),
    .o_zero     (w_zero)
  );

  assign w_len_bad  = (length == '0) || (length > LEN_W'(MAX_LEN));
  assign w_enc_last = CNT_W'(r_len) - CNT_W'(1);

  // Each phase loads count-1 and leaves on the cycle the counter reads zero
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_term_nxt  = r_term;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_valid && !abort) begin
          if (w_len_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_len_nxt   = length;
            w_term_nxt  = term_en;
            w_state_nxt = ST_CLEAR;
            w_load      = 1'b1;
            w_load_val  = CLR_LOAD;
          end
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_zero) begin
          w_state_nxt = ST_ENCODE;
          w_load      = 1'b1;
          w_load_val  = w_enc_last;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_ENCODE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_zero) begin
          if (r_term && (TAIL_CYCLES > 0)) begin
            w_state_nxt = ST_TAIL;
            w_load      = 1'b1;
            w_load_val  = TAIL_LOAD;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_TAIL: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_zero) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_err_nxt   = abort;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from next state/count so they line up with r_state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_term    <= 1'b0;
      r_ready   <= 1'b1;
      r_clr     <= 1'b0;
      r_enable  <= 1'b0;
      r_tail_en <= 1'b0;
      r_bit_idx <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_term    <= w_term_nxt;
      r_ready   <= (w_state_nxt == ST_IDLE);
      r_clr     <= (w_state_nxt == ST_CLEAR);
      r_enable  <= (w_state_nxt == ST_ENCODE);
      r_tail_en <= (w_state_nxt == ST_TAIL);
      r_bit_idx <= (w_state_nxt == ST_ENCODE) ? LEN_W'(w_enc_last - w_cnt_nxt) : '0;
      r_done    <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
      r_err     <= w_err_nxt;
    end
  end

  assign ready   = r_ready;
  assign clr     = r_clr;
  assign enable  = r_enable;
  assign tail_en = r_tail_en;
  assign bit_idx = r_bit_idx;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_turbo_ctrl_fsm.sv
// Directed bench for turbo_ctrl_fsm: expected per-cycle output words are queued
// when a request is driven and compared one per clock.
module tb_turbo_ctrl_fsm;

  typedef logic [22:0] word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_valid = 1'b0;
  logic [16:0] length = '0;
  logic        term_en = 1'b0;
  logic        abort = 1'b0;
  logic        ready, clr, enable, tail_en, done, err;
  logic [16:0] bit_idx;

  int    checks = 0;
  int    failures = 0;
  word_t q[$];

  always #5 clk = ~clk;

  turbo_ctrl_fsm #(
    .LEN_W       (17),
    .MAX_LEN     (6144),
    .CLR_CYCLES  (1),
    .TAIL_CYCLES (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_valid (data_valid),
    .length     (length),
    .term_en    (term_en),
    .abort      (abort),
    .ready      (ready),
    .clr        (clr),
    .enable     (enable),
    .tail_en    (tail_en),
    .bit_idx    (bit_idx),
    .done       (done),
    .err        (err)
  );

  function automatic word_t mk(input bit rdy, input bit c, input bit e, input bit t,
                               input bit d, input bit er, input int idx);
    return {rdy, c, e, t, d, er, 17'(idx)};
  endfunction

  function automatic word_t idle_w();
    return mk(1, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic word_t err_w();
    return mk(1, 0, 0, 0, 0, 1, 0);
  endfunction

  task automatic push_block(input int len, input bit term);
    q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < len; i++) q.push_back(mk(0, 0, 1, 0, 0, 0, i));
    if (term) for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
  endtask

  task automatic compare(input string tag, input word_t exp);
    word_t obs;
    obs = {ready, clr, enable, tail_en, done, err, bit_idx};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={rdy,clr,en,tail,done,err,idx}=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    word_t exp;
    @(posedge clk);
    #1;
    exp = (q.size() > 0) ? q.pop_front() : idle_w();
    compare(tag, exp);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 compare("reset_values", idle_w());
    @(posedge clk);
    #1 reset = 1'b1;
    step("idle_after_reset");

    // length=5 with termination
    length = 17'd5; term_en = 1'b1; data_valid = 1'b1;
    push_block(5, 1);
    step("t1_accept");
    data_valid = 1'b0;
    steps("t1_block", 9);
    step("t1_ready_back");

    // length=5 without termination
    length = 17'd5; term_en = 1'b0; data_valid = 1'b1;
    push_block(5, 0);
    step("t2_accept");
    data_valid = 1'b0;
    steps("t2_block", 6);
    step("t2_idle");

    // illegal lengths
    length = 17'd0; data_valid = 1'b1;
    q.push_back(err_w());
    step("t3_len0_err");
    data_valid = 1'b0;
    step("t3_len0_idle");
    length = 17'd6145; data_valid = 1'b1;
    q.push_back(err_w());
    step("t3_len6145_err");
    data_valid = 1'b0;
    step("t3_len6145_idle");

    // shortest and longest legal lengths
    length = 17'd1; term_en = 1'b1; data_valid = 1'b1;
    push_block(1, 1);
    step("t3_len1_accept");
    data_valid = 1'b0;
    steps("t3_len1_block", 5);
    step("t3_len1_idle");
    length = 17'd6144; term_en = 1'b0; data_valid = 1'b1;
    push_block(6144, 0);
    step("t3_len6144_accept");
    data_valid = 1'b0;
    steps("t3_len6144_block", 6145);
    step("t3_len6144_idle");

    // abort during bit_idx=3
    length = 17'd8; term_en = 1'b1; data_valid = 1'b1;
    q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(mk(0, 0, 1, 0, 0, 0, i));
    q.push_back(err_w());
    step("t4_accept");
    data_valid = 1'b0;
    steps("t4_encode", 4);
    abort = 1'b1;
    step("t4_abort_err");
    abort = 1'b0;
    step("t4_idle");

    // abort in IDLE blocks acceptance with no error
    length = 17'd4; data_valid = 1'b1; abort = 1'b1;
    step("t4_idle_abort");
    data_valid = 1'b0; abort = 1'b0;
    step("t4_idle_abort_after");

    // asynchronous reset during TAIL
    length = 17'd2; term_en = 1'b1; data_valid = 1'b1;
    push_block(2, 1);
    step("t5_accept");
    data_valid = 1'b0;
    steps("t5_to_tail", 3);
    reset = 1'b0;
    #1 compare("t5_async_reset", idle_w());
    q.delete();
    step("t5_in_reset");
    reset = 1'b1;
    length = 17'd2; term_en = 1'b0; data_valid = 1'b1;
    push_block(2, 0);
    step("t5_reaccept");
    data_valid = 1'b0;
    steps("t5_block", 3);
    step("t5_idle");

    // data_valid held, length/term_en changed mid-block
    length = 17'd3; term_en = 1'b0; data_valid = 1'b1;
    push_block(3, 0);
    q.push_back(idle_w());
    push_block(4, 0);
    step("t6_accept");
    length = 17'd4; term_en = 1'b1;
    steps("t6_block", 4);
    term_en = 1'b0;
    step("t6_ready");
    step("t6_reaccept");
    data_valid = 1'b0;
    steps("t6_block2", 5);
    step("t6_idle");

    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drained observed=%0d expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turbo_ctrl_fsm.md
TURBO_CTRL_FSM -- requirements
Module: turbo_ctrl_fsm

Interface
REQ-001 Parameter LEN_W, default 17: width of length and bit_idx.
REQ-002 Parameter MAX_LEN, default 6144: largest legal block length in bits.
REQ-003 Parameter CLR_CYCLES, default 1, min 1: cycles clr is held before encoding.
REQ-004 Parameter TAIL_CYCLES, default 3, min 0: trellis-termination cycles.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port data_valid, input, 1: block start request.
REQ-008 Port length, input, LEN_W: number of information bits; sampled on accept.
REQ-009 Port term_en, input, 1: tail phase requested; sampled on accept.
REQ-010 Port abort, input, 1: synchronous cancel of the block in progress.
REQ-011 Port ready, output, 1: high only in IDLE; a request can be accepted.
REQ-012 Port clr, output, 1: encoder register clear.
REQ-013 Port enable, output, 1: encoder shift enable, one information bit per cycle.
REQ-014 Port tail_en, output, 1: encoder tail/termination mode.
REQ-015 Port bit_idx, output, LEN_W: index of the bit being encoded while enable=1, else 0.
REQ-016 Port done, output, 1: one-cycle pulse on normal block completion.
REQ-017 Port err, output, 1: one-cycle pulse on illegal length or abort.

Function
REQ-018 States SHALL be IDLE, CLEAR, ENCODE, TAIL, DONE; all outputs SHALL be registered and decoded from the state and counter only.
REQ-019 Accept SHALL occur on an edge where state=IDLE, data_valid=1 and abort=0; data_valid SHALL be ignored in every other state.
REQ-020 On accept with length=0 or length>MAX_LEN: stay in IDLE, err=1 for the next cycle, nothing latched.
REQ-021 On legal accept: latch length and term_en, go to CLEAR; clr=1 for exactly CLR_CYCLES cycles starting the cycle after accept.
REQ-022 ENCODE: enable=1 for exactly the latched length consecutive cycles; bit_idx runs 0..length-1, one per cycle.
REQ-023 After the last ENCODE cycle: go to TAIL when latched term_en=1 and TAIL_CYCLES>0, otherwise go to DONE.
REQ-024 TAIL: tail_en=1 and enable=0 for exactly TAIL_CYCLES cycles, then DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE with ready=1 on the following cycle.
REQ-026 clr, enable and tail_en SHALL be mutually exclusive in every cycle.
REQ-027 abort=1 in CLEAR, ENCODE, TAIL or DONE: next state IDLE; err=1 for one cycle; no done; enable, clr and tail_en drop in the same edge.
REQ-028 abort=1 in IDLE SHALL block acceptance and SHALL NOT pulse err.
REQ-029 Changes to length or term_en after accept SHALL have no effect on the block in progress.
REQ-030 Phase counter width SHALL be the maximum of LEN_W, clog2(CLR_CYCLES+1) and clog2(TAIL_CYCLES+1); it SHALL never wrap during a legal block.
REQ-031 Minimum accept-to-accept spacing SHALL be CLR_CYCLES+length+tail+2 cycles, where tail is TAIL_CYCLES or 0.

Reset
REQ-032 reset=0 SHALL immediately force: state IDLE, clr=0, enable=0, tail_en=0, done=0, err=0, bit_idx=0, ready=1, latched length and term_en cleared.
REQ-033 Reset asserted mid-block SHALL discard the block with no done or err pulse; the first accept is possible on the first edge after reset releases.

Structure
REQ-034 The state enumeration and parameter defaults SHALL live in shared package turbo_pkg.
REQ-035 The phase counter SHALL be a sub-module, turbo_phase_cnt: a loadable down-counter with load, decrement and zero flag.

Verification
REQ-036 length=5, term_en=1, defaults -> clr 1 cycle, enable 5 cycles (bit_idx 0..4), tail_en 3 cycles, done pulse; ready back after 11 cycles.
REQ-037 length=5, term_en=0 -> enable 5 cycles, no tail_en, done on the next cycle.
REQ-038 length=0, then length=6145 -> err pulse each time, state stays IDLE, no clr.
REQ-039 length=8, abort during bit_idx=3 -> enable drops at the next edge, err pulse, no done, ready=1.
REQ-040 reset pulsed low during TAIL -> all outputs at reset values immediately; new length=2 request accepted after release completes normally.
REQ-041 data_valid held high through a whole block with length changed mid-block -> exactly one block of the original length, then re-accept in IDLE.
